// File: rtl/apb_pkg.sv
// ============================================================================
// apb_pkg : shared types and defaults for the APB3 requester
// Rev 1.0
// ============================================================================
`default_nettype none

package apb_pkg;

  localparam int APB_DEFAULT_WIDTH      = 8;
  localparam int APB_DEFAULT_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_DEFAULT_WIDTH-1:0] rdata;
    logic                         err;
  } apb_rsp_t;

endpackage

`default_nettype wire

// File: rtl/apb_master_timer.sv
// ============================================================================
// apb_master_timer : ACCESS wait-state counter with clear, enable and expiry
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_master_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flags the stalled cycle whose increment would bring the count to LIMIT.
  assign expired_o = en_i && (count_q == CNT_W'(LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/apb_master.sv
// ============================================================================
// apb_master : valid/ready command to single APB3 transfer requester
// Optional wait-state timeout enabled by defining APB_MASTER_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_master
  import apb_pkg::*;
#(
  parameter int WIDTH      = APB_DEFAULT_WIDTH,
  parameter int ADDR_WIDTH = APB_DEFAULT_ADDR_WIDTH
`ifdef APB_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 15
`endif
) (
  input  logic                  pclk_i,
  input  logic                  preset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [WIDTH-1:0]      cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [WIDTH-1:0]      pwdata_o,
  input  logic [WIDTH-1:0]      prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [WIDTH-1:0]      pwdata_q, pwdata_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  timer_expired;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_timer #(
    .LIMIT     (TIMEOUT)
  ) u_timer (
    .clk_i     (pclk_i),
    .rst_i     (preset_i),
    .clr_i     (state_q == ST_SETUP),
    .en_i      ((state_q == ST_ACCESS) && !pready_i),
    .expired_o (timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          paddr_d  = cmd_addr_i;
          pwrite_d = cmd_write_i;
          pwdata_d = cmd_wdata_i;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // A ready slave takes priority over an expiring timer.
        if (pready_i) begin
          rdata_d = pwrite_q ? '0 : prdata_i;
          err_d   = pslverr_i;
          state_d = ST_RESP;
        end else if (timer_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE) && !preset_i;
  assign psel_o      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable_o   = (state_q == ST_ACCESS);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// ============================================================================
// tb_apb_master : directed self-checking bench for apb_master
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_apb_master;

  localparam int MAXC = 512;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TIMEOUT = 15;
`endif

  logic       pclk = 1'b0;
  logic       preset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [3:0] paddr;
  logic [7:0] pwdata, prdata;
  logic       pready, pslverr;

  apb_master #(
    .WIDTH       (8),
    .ADDR_WIDTH  (4)
  ) dut (
    .pclk_i      (pclk),
    .preset_i    (preset),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .psel_o      (psel),
    .penable_o   (penable),
    .pwrite_o    (pwrite),
    .paddr_o     (paddr),
    .pwdata_o    (pwdata),
    .prdata_i    (prdata),
    .pready_i    (pready),
    .pslverr_i   (pslverr)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Expected per-cycle output values, filled transaction by transaction.
  logic       e_psel[MAXC], e_pen[MAXC], e_valid[MAXC], e_ready[MAXC];
  logic       e_pwrite[MAXC], e_err[MAXC];
  logic [3:0] e_paddr[MAXC];
  logic [7:0] e_pwdata[MAXC], e_rdata[MAXC];

  typedef struct {
    int         h;
    int         n_psel;
    int         n_pen;
    int         psel_rise;
    int         rsp_first;
    int         rsp_last;
    logic [7:0] rd;
    logic       err;
  } xres_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Transfer timeline: handshake in cycle h, SETUP for one cycle, ACCESS for
  // acc cycles, RESP held for rhold extra cycles, then back to idle.
  task automatic model_xfer(input int h, input logic wr, input logic [3:0] a,
                            input logic [7:0] wd, input int acc, input logic [7:0] rd,
                            input logic er, input int rhold);
    for (int c = h + 1; c < MAXC; c++) begin
      e_paddr[c]  = a;
      e_pwrite[c] = wr;
      e_pwdata[c] = wd;
    end
    for (int c = h + 1; c <= h + 2 + acc + rhold && c < MAXC; c++) begin
      e_ready[c] = 1'b0;
      e_psel[c]  = (c <= h + 1 + acc);
      e_pen[c]   = (c >= h + 2) && (c <= h + 1 + acc);
      e_valid[c] = (c >= h + 2 + acc);
      e_rdata[c] = rd;
      e_err[c]   = er;
    end
  endtask

  task automatic model_reset(input int c0);
    e_ready[c0] = 1'b0;
    for (int c = c0 + 1; c < MAXC; c++) begin
      e_psel[c] = 1'b0; e_pen[c] = 1'b0; e_valid[c] = 1'b0; e_ready[c] = 1'b1;
      e_paddr[c] = '0; e_pwrite[c] = 1'b0; e_pwdata[c] = '0;
    end
  endtask

  always @(negedge pclk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      chk("psel",      32'(psel),      32'(e_psel[cyc]));
      chk("penable",   32'(penable),   32'(e_pen[cyc]));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_valid[cyc]));
      chk("cmd_ready", 32'(cmd_ready), 32'(e_ready[cyc]));
      chk("paddr",     32'(paddr),     32'(e_paddr[cyc]));
      chk("pwrite",    32'(pwrite),    32'(e_pwrite[cyc]));
      chk("pwdata",    32'(pwdata),    32'(e_pwdata[cyc]));
      if (e_valid[cyc]) begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata[cyc]));
        chk("rsp_err",   32'(rsp_err),   32'(e_err[cyc]));
      end
    end
  end

  task automatic xfer(input logic wr, input logic [3:0] a, input logic [7:0] wd,
                      input int waits, input logic [7:0] rd, input logic se, input int rhold,
                      input logic pre_v, input logic pre_wr, input logic [3:0] pre_a,
                      input logic [7:0] pre_wd, output xres_t r);
    int   acc;
    logic abort;
    acc   = waits + 1;
    abort = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    if (waits >= TIMEOUT) begin
      abort = 1'b1;
      acc   = TIMEOUT;
    end
`endif
    r.h = cyc; r.n_psel = 0; r.n_pen = 0; r.psel_rise = -1;
    r.rsp_first = -1; r.rsp_last = -1; r.rd = 'x; r.err = 1'bx;
    model_xfer(r.h, wr, a, wd, acc, (abort || wr) ? 8'h00 : rd, abort || se, rhold);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    @(posedge pclk); #1;
    if (pre_v) begin
      cmd_write = pre_wr; cmd_addr = pre_a; cmd_wdata = pre_wd;
    end else begin
      cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 4'hE; cmd_wdata = 8'hFF;
    end
    for (int i = 0; i < acc + 2 + rhold; i++) begin
      if (psel) begin
        r.n_psel++;
        if (r.psel_rise < 0) r.psel_rise = cyc;
      end
      if (penable) r.n_pen++;
      if (rsp_valid) begin
        if (r.rsp_first < 0) begin
          r.rsp_first = cyc; r.rd = rsp_rdata; r.err = rsp_err;
        end
        r.rsp_last = cyc;
      end
      pready    = (i == acc) && !abort;
      prdata    = pready ? rd : 8'hC3;
      pslverr   = pready ? se : (i >= 1 && i <= acc);
      rsp_ready = (i == acc + 1 + rhold);
      @(posedge pclk); #1;
    end
    pready = 1'b0; prdata = 8'h00; pslverr = 1'b0; rsp_ready = 1'b0;
  endtask

  xres_t r1, r2;
  int    h;

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      e_psel[c] = 1'b0; e_pen[c] = 1'b0; e_valid[c] = 1'b0; e_ready[c] = (c >= 4);
      e_pwrite[c] = 1'b0; e_err[c] = 1'b0; e_paddr[c] = '0; e_pwdata[c] = '0; e_rdata[c] = '0;
    end
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (4) @(posedge pclk);
    #1 preset = 1'b0;
    #1 chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Zero-wait write
    xfer(1'b1, 4'h3, 8'hA5, 0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 4'h0, 8'h00, r1);
    chk("wr_psel_cycles", r1.n_psel, 32'd2);
    chk("wr_rsp_latency", r1.rsp_first - r1.h, 32'd3);
    chk("wr_rsp_err", 32'(r1.err), 32'd0);

    // Read with two wait states
    xfer(1'b0, 4'h3, 8'h00, 2, 8'hA5, 1'b0, 0, 1'b0, 1'b0, 4'h0, 8'h00, r1);
    chk("rd_penable_cycles", r1.n_pen, 32'd3);
    chk("rd_rdata", 32'(r1.rd), 32'hA5);
    chk("rd_err", 32'(r1.err), 32'd0);

    // Slave error on read
    xfer(1'b0, 4'hF, 8'h00, 0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 4'h0, 8'h00, r1);
    chk("slverr_err", 32'(r1.err), 32'd1);
    chk("slverr_rdata", 32'(r1.rd), 32'h00);

    // Back-to-back with the response held off for 5 cycles
    xfer(1'b1, 4'h7, 8'h3C, 0, 8'h00, 1'b0, 5, 1'b1, 1'b0, 4'h7, 8'h11, r1);
    xfer(1'b0, 4'h7, 8'h11, 1, 8'h3C, 1'b0, 0, 1'b0, 1'b0, 4'h0, 8'h00, r2);
    chk("b2b_rsp_hold", r1.rsp_last - r1.rsp_first, 32'd5);
    chk("b2b_psel_gap", r2.psel_rise - r1.rsp_last, 32'd2);
    chk("b2b_rdata", 32'(r2.rd), 32'h3C);

    // Write with slave error: read data must be zero
    xfer(1'b1, 4'h9, 8'h5A, 3, 8'hEE, 1'b1, 1, 1'b0, 1'b0, 4'h0, 8'h00, r1);
    chk("wr_err_rdata", 32'(r1.rd), 32'h00);
    chk("wr_err_err", 32'(r1.err), 32'd1);

`ifdef APB_MASTER_TIMEOUT_EN
    xfer(1'b0, 4'h2, 8'h00, 40, 8'h77, 1'b0, 0, 1'b0, 1'b0, 4'h0, 8'h00, r1);
    chk("tmo_psel_cycles", r1.n_psel, 32'd16);
    chk("tmo_err", 32'(r1.err), 32'd1);
    chk("tmo_rdata", 32'(r1.rd), 32'h00);
    xfer(1'b0, 4'h2, 8'h00, 14, 8'h5A, 1'b0, 0, 1'b0, 1'b0, 4'h0, 8'h00, r1);
    chk("tmo_edge_penable", r1.n_pen, 32'd15);
    chk("tmo_edge_err", 32'(r1.err), 32'd0);
    chk("tmo_edge_rdata", 32'(r1.rd), 32'h5A);
`endif

    // Reset pulse during ACCESS
    h = cyc;
    model_xfer(h, 1'b1, 4'hA, 8'h99, 10, 8'h00, 1'b0, 0);
    model_reset(h + 3);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hA; cmd_wdata = 8'h99;
    @(posedge pclk); #1 cmd_valid = 1'b0;
    @(posedge pclk); #1;
    @(posedge pclk); #1 preset = 1'b1;
    #1 chk("rst_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge pclk); #1 preset = 1'b0;
    #1;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_ready_high", 32'(cmd_ready), 32'd1);

    // Normal operation after reset
    xfer(1'b0, 4'h1, 8'h00, 0, 8'h5A, 1'b0, 0, 1'b0, 1'b0, 4'h0, 8'h00, r1);
    chk("post_rst_rdata", 32'(r1.rd), 32'h5A);

    repeat (2) @(posedge pclk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_master.md
# apb_master

APB3 requester that converts a simple valid/ready command interface into single APB3 transfers toward the APB memory slave. It sits directly upstream of the slave: it drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, waits through PREADY wait states, and returns PRDATA/PSLVERR as a held response. It issues one transfer at a time, with an optional wait-state timeout so a stalled slave cannot hang the bus.

## Interface
- WIDTH, 8, data width of command write data, PWDATA and PRDATA
- ADDR_WIDTH, 4, address width of command address and PADDR
- TIMEOUT, 15, maximum ACCESS cycles without PREADY before abort (used only when the timeout feature is compiled in)

Ports:
- pclk_i  in  1  clock; all logic on the rising edge
- preset_i  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  master can accept a command
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_WIDTH  target address
- cmd_wdata_i  in  WIDTH  write data
- rsp_valid_o  out  1  response present; held until accepted
- rsp_ready_i  in  1  consumer accepts the response
- rsp_rdata_o  out  WIDTH  read data (0 for writes and for aborted transfers)
- rsp_err_o  out  1  PSLVERR was sampled, or the transfer timed out
- psel_o, penable_o, pwrite_o  out  1 each  APB control
- paddr_o  out  ADDR_WIDTH  APB address
- pwdata_o  out  WIDTH  APB write data
- prdata_i  in  WIDTH  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

## Operation
- FSM states and transitions:
  - IDLE: cmd_ready_o = 1. When cmd_valid_i && cmd_ready_o, latch write, addr and wdata into paddr_o, pwrite_o and pwdata_o, then go to SETUP.
  - SETUP: psel_o = 1, penable_o = 0. Unconditionally go to ACCESS.
  - ACCESS: psel_o = 1, penable_o = 1. Stay until pready_i = 1.
    - When pready_i = 1: capture prdata_i (reads only; writes return 0) and pslverr_i, drop psel_o and penable_o, go to RESP.
  - RESP: rsp_valid_o = 1. When rsp_ready_i = 1, go to IDLE.
- cmd_ready_o is 1 only in IDLE and never while preset_i = 1. Commands are not buffered.
- paddr_o, pwrite_o and pwdata_o are stable from SETUP through the last ACCESS cycle, and keep the last value otherwise.
- rsp_rdata_o and rsp_err_o are stable while rsp_valid_o = 1.
- pslverr_i and prdata_i are ignored when pready_i = 0.
- An unencoded state returns to IDLE.

## Timing
- Reset value of every output is 0; state is IDLE. cmd_ready_o rises in the first cycle after preset_i deasserts.
- Command handshake at edge E0:
  - psel_o is high after E0.
  - penable_o is high after E1.
  - pready_i is first sampled at E2.
  - With zero wait states, rsp_valid_o is high after E2.
- Each cycle of pready_i = 0 in ACCESS adds one cycle.
- Minimum issue rate is one transfer per 4 cycles (SETUP, ACCESS, RESP, IDLE) when rsp_ready_i is tied to 1.
- rsp_ready_i asserted in the same cycle rsp_valid_o rises completes the response at that edge.
- Reset asserted mid-transfer: at the next edge psel_o, penable_o and rsp_valid_o are 0 and state is IDLE. The pending response is discarded.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with pready_i = 0.
  - When the counter reaches TIMEOUT, the transfer aborts: psel_o and penable_o drop, rsp_err_o = 1, rsp_rdata_o = 0, go to RESP.
  - pready_i = 1 in the same cycle the counter reaches TIMEOUT wins: normal completion.
- Undefined: no counter; ACCESS waits indefinitely for pready_i.

## Structure
- Shared package apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - the default WIDTH and ADDR_WIDTH constants;
  - a response struct {rdata, err}.
- Sub-module apb_master_timer: the wait counter with clear, enable and expired flag, instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Write addr 4'h3, data 8'hA5; slave with zero wait states and pslverr_i = 0 -> psel_o high for 2 cycles with pwrite_o = 1, pwdata_o = 8'hA5; rsp_valid_o 3 cycles after the handshake; rsp_err_o = 0.
- Read addr 4'h3; slave returns 8'hA5 after 2 wait states -> penable_o high for 3 cycles; rsp_rdata_o = 8'hA5; rsp_err_o = 0.
- Read addr 4'hF; slave gives pready_i = 1 with pslverr_i = 1 -> rsp_err_o = 1, rsp_rdata_o = 8'h00.
- Back-to-back commands with rsp_ready_i held 0 for 5 cycles -> cmd_ready_o stays 0 until the response handshake; the second transfer's psel_o rises 2 cycles after that handshake.
- Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT = 15) with pready_i stuck at 0 -> after 15 ACCESS cycles psel_o = 0, rsp_err_o = 1, rsp_rdata_o = 8'h00.
- preset_i pulsed during ACCESS -> at the next edge all outputs are 0; cmd_ready_o = 1 one cycle after reset release.
